hart_irq_ctrl: RTL and testbench
================================

# hart_irq_ctrl

Parametrised interrupt conditioning block sitting between the SoC's asynchronous interrupt sources and `NrHarts` Ariane cores. For every hart it synchronises the five async lines (irq[1:0], ipi, time_irq, debug_req), applies per-source level/edge mode and enable masking, and drives the core's interrupt inputs. A simple req/gnt register port configures modes and masks and services pending bits. This is the multi-hart successor of the single-hart top, which wires raw async lines straight into the core.

## Interface
- `NrHarts`, default 1: number of harts served; legal range 1..64.
- `SyncStages`, default 2: synchroniser flops per input; legal range 2..4.
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `irq_i`  in  2*NrHarts  async external lines; bits [2h+1:2h] belong to hart h (bit 0 = M-level, bit 1 = S-level).
- `ipi_i`  in  NrHarts  async inter-processor interrupt, one per hart.
- `time_irq_i`  in  NrHarts  async timer interrupt, one per hart.
- `debug_req_i`  in  NrHarts  async debug request, one per hart.
- `cfg_req_i`  in  1  register access request.
- `cfg_we_i`  in  1  1 = write, 0 = read.
- `cfg_addr_i`  in  8  word address; [7:2] = hart, [1:0] = register.
- `cfg_wdata_i`  in  32  write data.
- `cfg_gnt_o`  out  1  grant.
- `cfg_rvalid_o`  out  1  response valid (reads and writes).
- `cfg_rdata_o`  out  32  read data.
- `irq_o`  out  2*NrHarts  conditioned irq lines to the cores.
- `ipi_o`, `time_irq_o`, `debug_req_o`  out  NrHarts each  conditioned lines to the cores.

## Operation
- Source index k per hart: 0 = irq[0], 1 = irq[1], 2 = ipi, 3 = time_irq, 4 = debug_req.
- Per-hart registers, each using bits [4:0]; bits [31:5] read 0 and ignore writes:
  - reg 0 ENABLE (rw): output mask.
  - reg 1 MODE (rw): 1 = rising-edge, 0 = level.
  - reg 2 PENDING: reads (MODE ? pending : synced level). A write of 1 clears an edge-mode pending bit.
  - reg 3 SWSET (wo, reads 0): a write of 1 sets the pending bit of an edge-mode source. Ignored for level-mode sources.
- Each input passes through a `SyncStages`-deep flop chain. A `prev` flop holds the last synced value. A rising edge is `sync & ~prev`.
- Edge detect sets `pending[h][k]`. Pending stays set until a W1C write.
- Output per source: `ENABLE & (MODE ? pending : sync)`, registered.
- Disabling a source masks its output but does not clear pending.
- Writing MODE from 1 to 0 clears that source's pending bit.
- Simultaneous edge (or SWSET) and W1C on the same bit: set wins.
- Hart index >= `NrHarts`: writes are ignored; reads return 0. The access is still granted and answered.

## Timing
- `cfg_gnt_o = cfg_req_i`, combinational. No stalls.
- `cfg_rvalid_o` is asserted exactly one cycle after each granted access, for one cycle. `cfg_rdata_o` is valid with it and holds 0 when rvalid is low.
- Register writes take effect at the grant edge. A read in the following cycle returns the new value.
- Level latency: input change to output change is `SyncStages`+1 cycles.
- Edge latency: input rise to output high is `SyncStages`+2 cycles.
- W1C or SWSET at cycle n: the output reflects the change at cycle n+1.
- Reset values: all sync, prev and pending flops, ENABLE, MODE and every output are 0; `cfg_rvalid_o` = 0 and `cfg_rdata_o` = 0.
- Reset mid-operation clears all state at the next edge. Any in-flight response is dropped (no rvalid after reset). An input still high after reset re-propagates through the synchroniser and, in edge mode, produces a fresh pending once mode is re-programmed.

## Test plan
- Reset, `NrHarts`=2, `SyncStages`=2: all outputs, `cfg_rvalid_o` and `cfg_rdata_o` read 0; reads of hart1 regs 0..3 return 0x0.
- Level path: write hart0 ENABLE=0x1F and MODE=0x00, then raise `time_irq_i[0]` at cycle 0 -> `time_irq_o[0]` = 1 at cycle 3. Drop the input -> the output is 0 three cycles later.
- Edge path: hart1 ENABLE=0x04 and MODE=0x04; pulse `ipi_i[1]` high for 3 cycles -> `ipi_o[1]` rises 4 cycles after the input rise and stays high. PENDING read returns 0x04. Write PENDING=0x04 -> the output is 0 the next cycle.
- Collision: an edge on `debug_req_i[0]` detected in the same cycle as a W1C of bit 4 -> pending stays 1 and `debug_req_o[0]` stays 1.
- Masking and mode switch: a pending edge with ENABLE cleared -> output 0 while PENDING still reads 1. Re-enabling -> output 1. Writing MODE=0 -> pending cleared.
- Out-of-range and SWSET: a write to hart 5 (addr 0x14) with `NrHarts`=2 is granted, rvalid follows one cycle later, and no state changes. SWSET bit 0 on hart0 in edge mode -> `irq_o[0]` = 1 one cycle later.

Source files
------------

// File: rtl/hart_irq_ctrl_if.sv
// Configuration port of the hart interrupt conditioner.
//
// Handshake: the master holds cfg_req_i high for one cycle per access; the
// slave grants in the same cycle (cfg_gnt_o follows cfg_req_i, never stalls),
// so every cycle with cfg_req_i high is one accepted access. Exactly one
// cycle later the slave pulses cfg_rvalid_o for one cycle, with cfg_rdata_o
// carrying the read value (0 for writes and whenever cfg_rvalid_o is low).
interface hart_irq_ctrl_if;
    logic        cfg_req_i;
    logic        cfg_we_i;
    logic [7:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic        cfg_gnt_o;
    logic        cfg_rvalid_o;
    logic [31:0] cfg_rdata_o;

    modport master (
        output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
    );

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o
    );
endinterface

// File: rtl/hart_irq_ctrl.sv
// Interrupt conditioning for NrHarts cores: synchronises the five async
// interrupt lines of each hart, applies per-source level/edge mode and
// enable masking, and drives registered interrupt outputs. Per-hart
// registers (word address [7:2] = hart, [1:0] = register):
//   0 ENABLE  rw   output mask
//   1 MODE    rw   1 = rising edge, 0 = level
//   2 PENDING r/w1c  reads MODE ? pending : synced level
//   3 SWSET   wo   sets pending of edge-mode sources, reads 0
// Source bit order per hart: irq[0], irq[1], ipi, time_irq, debug_req.
module hart_irq_ctrl #(
    parameter int NrHarts    = 1,
    parameter int SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2*NrHarts-1:0] irq_i,
    input  logic [NrHarts-1:0]   ipi_i,
    input  logic [NrHarts-1:0]   time_irq_i,
    input  logic [NrHarts-1:0]   debug_req_i,
    hart_irq_ctrl_if.slave       cfg,
    output logic [2*NrHarts-1:0] irq_o,
    output logic [NrHarts-1:0]   ipi_o,
    output logic [NrHarts-1:0]   time_irq_o,
    output logic [NrHarts-1:0]   debug_req_o
);

    typedef logic [4:0] src_t;

    localparam logic [1:0] RegEnable  = 2'd0;
    localparam logic [1:0] RegMode    = 2'd1;
    localparam logic [1:0] RegPending = 2'd2;
    localparam logic [1:0] RegSwset   = 2'd3;

    src_t raw       [NrHarts];
    src_t sync_q    [NrHarts][SyncStages];
    src_t sync      [NrHarts];
    src_t prev_q    [NrHarts];
    src_t rise      [NrHarts];
    src_t pending_q [NrHarts];
    src_t pending_d [NrHarts];
    src_t enable_q  [NrHarts];
    src_t enable_d  [NrHarts];
    src_t mode_q    [NrHarts];
    src_t mode_d    [NrHarts];
    src_t out_q     [NrHarts];
    src_t out_d     [NrHarts];
    src_t w1c       [NrHarts];
    src_t swset     [NrHarts];
    src_t mode_clr  [NrHarts];

    logic [5:0]  hart_sel;
    logic [1:0]  reg_sel;
    logic        hart_ok;
    logic        wr_en;
    src_t        wdata;
    logic [31:0] rd_val;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        unused_wdata;

    assign hart_sel     = cfg.cfg_addr_i[7:2];
    assign reg_sel      = cfg.cfg_addr_i[1:0];
    assign hart_ok      = ({1'b0, hart_sel} < 7'(NrHarts));
    assign wr_en        = cfg.cfg_req_i & cfg.cfg_we_i & hart_ok;
    assign wdata        = cfg.cfg_wdata_i[4:0];
    assign unused_wdata = ^cfg.cfg_wdata_i[31:5];

    // Grant is immediate: the block never stalls an access.
    assign cfg.cfg_gnt_o    = cfg.cfg_req_i;
    assign cfg.cfg_rvalid_o = rvalid_q;
    assign cfg.cfg_rdata_o  = rdata_q;

    // Gather each hart's five async lines and derive synced level and rising edge.
    always_comb begin
        for (int h = 0; h < NrHarts; h++) begin
            raw[h]  = {debug_req_i[h], time_irq_i[h], ipi_i[h], irq_i[2*h+1], irq_i[2*h]};
            sync[h] = sync_q[h][SyncStages-1];
            rise[h] = sync_q[h][SyncStages-1] & ~prev_q[h];
        end
    end

    // Register write decode and next pending/output state per hart.
    always_comb begin
        for (int h = 0; h < NrHarts; h++) begin
            enable_d[h] = enable_q[h];
            mode_d[h]   = mode_q[h];
            w1c[h]      = '0;
            swset[h]    = '0;
            mode_clr[h] = '0;
            if (wr_en && (hart_sel == 6'(h))) begin
                case (reg_sel)
                    RegEnable:  enable_d[h] = wdata;
                    RegMode: begin
                        mode_d[h]   = wdata;
                        // Leaving edge mode discards any latched edge.
                        mode_clr[h] = mode_q[h] & ~wdata;
                    end
                    RegPending: w1c[h]   = wdata;
                    RegSwset:   swset[h] = wdata & mode_q[h];
                    default: ;
                endcase
            end
            // Sets (edge or software) beat a same-cycle W1C; a mode drop beats both.
            pending_d[h] = ((pending_q[h] & ~w1c[h]) | (rise[h] & mode_q[h]) | swset[h])
                           & ~mode_clr[h];
            out_d[h]     = enable_q[h] & ((mode_q[h] & pending_q[h]) | (~mode_q[h] & sync[h]));
        end
    end

    // Read mux; harts outside the populated range match nothing and read 0.
    always_comb begin
        rd_val = '0;
        for (int h = 0; h < NrHarts; h++) begin
            if (hart_sel == 6'(h)) begin
                case (reg_sel)
                    RegEnable:  rd_val = {27'b0, enable_q[h]};
                    RegMode:    rd_val = {27'b0, mode_q[h]};
                    RegPending: rd_val = {27'b0, (mode_q[h] & pending_q[h]) |
                                                 (~mode_q[h] & sync[h])};
                    default:    rd_val = '0;
                endcase
            end
        end
    end

    // All state: synchronisers, edge history, registers, outputs and response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int h = 0; h < NrHarts; h++) begin
                for (int s = 0; s < SyncStages; s++) begin
                    sync_q[h][s] <= '0;
                end
                prev_q[h]    <= '0;
                pending_q[h] <= '0;
                enable_q[h]  <= '0;
                mode_q[h]    <= '0;
                out_q[h]     <= '0;
            end
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            for (int h = 0; h < NrHarts; h++) begin
                sync_q[h][0] <= raw[h];
                for (int s = 1; s < SyncStages; s++) begin
                    sync_q[h][s] <= sync_q[h][s-1];
                end
                prev_q[h]    <= sync[h];
                pending_q[h] <= pending_d[h];
                enable_q[h]  <= enable_d[h];
                mode_q[h]    <= mode_d[h];
                out_q[h]     <= out_d[h];
            end
            rvalid_q <= cfg.cfg_req_i;
            rdata_q  <= (cfg.cfg_req_i && !cfg.cfg_we_i) ? rd_val : 32'h0;
        end
    end

    // Fan the registered per-hart vectors out to the core-facing lines.
    always_comb begin
        irq_o       = '0;
        ipi_o       = '0;
        time_irq_o  = '0;
        debug_req_o = '0;
        for (int h = 0; h < NrHarts; h++) begin
            irq_o[2*h]     = out_q[h][0];
            irq_o[2*h+1]   = out_q[h][1];
            ipi_o[h]       = out_q[h][2];
            time_irq_o[h]  = out_q[h][3];
            debug_req_o[h] = out_q[h][4];
        end
    end

endmodule

// File: tb/tb_hart_irq_ctrl.sv
// Directed bench for hart_irq_ctrl with two harts and two sync stages.
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
module tb_hart_irq_ctrl;

    localparam int NrHarts    = 2;
    localparam int SyncStages = 2;

    logic                 clk;
    logic                 rst;
    logic [2*NrHarts-1:0] irq_i;
    logic [NrHarts-1:0]   ipi_i;
    logic [NrHarts-1:0]   time_irq_i;
    logic [NrHarts-1:0]   debug_req_i;
    logic [2*NrHarts-1:0] irq_o;
    logic [NrHarts-1:0]   ipi_o;
    logic [NrHarts-1:0]   time_irq_o;
    logic [NrHarts-1:0]   debug_req_o;

    hart_irq_ctrl_if cfg_if ();

    hart_irq_ctrl #(
        .NrHarts    (NrHarts),
        .SyncStages (SyncStages)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_i       (irq_i),
        .ipi_i       (ipi_i),
        .time_irq_i  (time_irq_i),
        .debug_req_i (debug_req_i),
        .cfg         (cfg_if),
        .irq_o       (irq_o),
        .ipi_o       (ipi_o),
        .time_irq_o  (time_irq_o),
        .debug_req_o (debug_req_o)
    );

    // Clock and counters
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access: drive for one cycle, expect rvalid with the queued data next cycle.
    task automatic cfg_access(input logic we, input logic [7:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input string tag);
        logic [31:0] exp;
        cfg_if.cfg_req_i   = 1'b1;
        cfg_if.cfg_we_i    = we;
        cfg_if.cfg_addr_i  = addr;
        cfg_if.cfg_wdata_i = wdata;
        #1;
        check({tag, "_gnt"}, {31'b0, cfg_if.cfg_gnt_o}, 32'd1);
        exp_q.push_back(we ? 32'h0 : exp_rdata);
        @(posedge clk);
        #1;
        cfg_if.cfg_req_i   = 1'b0;
        cfg_if.cfg_we_i    = 1'b0;
        cfg_if.cfg_wdata_i = '0;
        check({tag, "_rvalid"}, {31'b0, cfg_if.cfg_rvalid_o}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_rdata"}, cfg_if.cfg_rdata_o, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] wdata, input string tag);
        cfg_access(1'b1, addr, wdata, 32'h0, tag);
    endtask

    task automatic cfg_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        cfg_access(1'b0, addr, 32'h0, exp, tag);
    endtask

    initial begin
        rst                = 1'b1;
        irq_i              = '0;
        ipi_i              = '0;
        time_irq_i         = '0;
        debug_req_i        = '0;
        cfg_if.cfg_req_i   = 1'b0;
        cfg_if.cfg_we_i    = 1'b0;
        cfg_if.cfg_addr_i  = '0;
        cfg_if.cfg_wdata_i = '0;
        repeat (3) tick();

        // Reset state
        check("rst_irq_o",    {28'b0, irq_o}, 32'h0);
        check("rst_ipi_o",    {30'b0, ipi_o}, 32'h0);
        check("rst_time_o",   {30'b0, time_irq_o}, 32'h0);
        check("rst_debug_o",  {30'b0, debug_req_o}, 32'h0);
        check("rst_rvalid",   {31'b0, cfg_if.cfg_rvalid_o}, 32'h0);
        check("rst_rdata",    cfg_if.cfg_rdata_o, 32'h0);
        rst = 1'b0;
        tick();
        for (int a = 4; a < 8; a++) begin
            cfg_read(8'(a), 32'h0, "rst_h1_reg");
        end

        // Level path on hart0 time_irq
        cfg_write(8'h00, 32'h1F, "lvl_en");
        cfg_write(8'h01, 32'h00, "lvl_mode");
        time_irq_i[0] = 1'b1;
        tick(); tick();
        check("lvl_rise_c2", {31'b0, time_irq_o[0]}, 32'd0);
        tick();
        check("lvl_rise_c3", {31'b0, time_irq_o[0]}, 32'd1);
        cfg_read(8'h02, 32'h08, "lvl_pending_level");
        time_irq_i[0] = 1'b0;
        tick(); tick();
        check("lvl_fall_c2", {31'b0, time_irq_o[0]}, 32'd1);
        tick();
        check("lvl_fall_c3", {31'b0, time_irq_o[0]}, 32'd0);

        // Edge path on hart1 ipi
        cfg_write(8'h04, 32'h04, "edge_en");
        cfg_write(8'h05, 32'h04, "edge_mode");
        ipi_i[1] = 1'b1;
        tick(); tick(); tick();
        check("edge_c3", {31'b0, ipi_o[1]}, 32'd0);
        ipi_i[1] = 1'b0;
        tick();
        check("edge_c4", {31'b0, ipi_o[1]}, 32'd1);
        repeat (4) tick();
        check("edge_hold", {31'b0, ipi_o[1]}, 32'd1);
        cfg_read(8'h06, 32'h04, "edge_pending");
        cfg_write(8'h06, 32'h04, "edge_w1c");
        check("edge_w1c_same", {31'b0, ipi_o[1]}, 32'd1);
        tick();
        check("edge_w1c_next", {31'b0, ipi_o[1]}, 32'd0);
        cfg_read(8'h06, 32'h00, "edge_pending_clr");

        // Collision: edge on hart0 debug_req with a same-cycle W1C
        cfg_write(8'h01, 32'h10, "col_mode");
        debug_req_i[0] = 1'b1;
        repeat (4) tick();
        check("col_first_edge", {31'b0, debug_req_o[0]}, 32'd1);
        debug_req_i[0] = 1'b0;
        repeat (3) tick();
        check("col_pending_hold", {31'b0, debug_req_o[0]}, 32'd1);
        debug_req_i[0] = 1'b1;
        tick(); tick();
        cfg_write(8'h02, 32'h10, "col_w1c");
        tick();
        check("col_out", {31'b0, debug_req_o[0]}, 32'd1);
        cfg_read(8'h02, 32'h10, "col_pending");
        debug_req_i[0] = 1'b0;
        repeat (3) tick();

        // Masking and mode switch
        cfg_write(8'h00, 32'h0F, "mask_dis");
        tick();
        check("mask_out", {31'b0, debug_req_o[0]}, 32'd0);
        cfg_read(8'h02, 32'h10, "mask_pending");
        cfg_write(8'h00, 32'h1F, "mask_en");
        tick();
        check("unmask_out", {31'b0, debug_req_o[0]}, 32'd1);
        cfg_write(8'h01, 32'h00, "mode_to_level");
        cfg_write(8'h01, 32'h10, "mode_to_edge");
        cfg_read(8'h02, 32'h00, "mode_pending_cleared");
        tick();
        check("mode_out", {31'b0, debug_req_o[0]}, 32'd0);

        // Upper bits ignored, out-of-range hart
        cfg_write(8'h04, 32'hFFFF_FFE4, "hi_bits_wr");
        cfg_read(8'h04, 32'h04, "hi_bits_rd");
        cfg_write(8'h14, 32'hFFFF_FFFF, "oor_wr");
        tick();
        check("oor_rvalid_drop", {31'b0, cfg_if.cfg_rvalid_o}, 32'd0);
        check("oor_rdata_idle", cfg_if.cfg_rdata_o, 32'h0);
        cfg_read(8'h14, 32'h0, "oor_rd");
        cfg_read(8'h04, 32'h04, "oor_h1_en");
        cfg_read(8'h05, 32'h04, "oor_h1_mode");
        cfg_read(8'h00, 32'h1F, "oor_h0_en");

        // SWSET: bit0 edge mode sets, bit1 level mode ignored
        cfg_write(8'h01, 32'h11, "sw_mode");
        cfg_write(8'h03, 32'h03, "sw_set");
        check("sw_same", {28'b0, irq_o}, 32'h0);
        tick();
        check("sw_next", {28'b0, irq_o}, 32'h1);
        cfg_read(8'h02, 32'h01, "sw_pending");
        cfg_read(8'h03, 32'h00, "sw_rd_zero");

        // Reset with an access in flight
        cfg_if.cfg_req_i  = 1'b1;
        cfg_if.cfg_we_i   = 1'b0;
        cfg_if.cfg_addr_i = 8'h00;
        rst = 1'b1;
        tick();
        cfg_if.cfg_req_i = 1'b0;
        rst = 1'b0;
        check("mrst_rvalid", {31'b0, cfg_if.cfg_rvalid_o}, 32'd0);
        check("mrst_irq_o", {28'b0, irq_o}, 32'h0);
        tick();
        check("mrst_no_late", {31'b0, cfg_if.cfg_rvalid_o}, 32'd0);
        cfg_read(8'h00, 32'h0, "mrst_en");
        cfg_read(8'h02, 32'h0, "mrst_pending");
        check("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
